// File: rtl/oem_bisu_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : oem_bisu_result_drain
// Purpose  : Output-end consumer of the odd-even merge / bidirectional
//            insertion sort pipeline. It collects N/P sorted P-wide beats into
//            an N-entry frame buffer and checks the sort order as the beats
//            arrive. It then replays the frame one element per handshake.
// Ports    : clk      - clock; all state changes on the rising edge
//            rst      - asynchronous active-low reset
//            ENin     - enable from sorter (ENout)
//            Vin      - beat valid from sorter (Vout)
//            INV      - expected order (0 non-decreasing, 1 non-increasing)
//            DI       - packed beat; lane 0 (bits W-1:0) is the earliest element
//            RDY      - downstream ready
//            DOut     - current element
//            Vo       - DOut valid
//            Last     - DOut is element N-1 of the frame
//            Done     - one-cycle pulse after the last element is accepted
//            OrderErr - frame order violation flag
//            Overrun  - sticky; a beat arrived while draining
//            Busy     - high outside IDLE
// Revision : 1.0 - initial release
// ============================================================================
module oem_bisu_result_drain #(
    parameter int W = 6,
    parameter int P = 4,
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ENin,
    input  logic           Vin,
    input  logic           INV,
    input  logic [P*W-1:0] DI,
    input  logic           RDY,
    output logic [W-1:0]   DOut,
    output logic           Vo,
    output logic           Last,
    output logic           Done,
    output logic           OrderErr,
    output logic           Overrun,
    output logic           Busy
);

    localparam int c_nb  = N / P;
    localparam int c_bcw = (c_nb > 1) ? $clog2(c_nb) : 1;
    localparam int c_rcw = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_bcw-1:0] c_last_beat = c_bcw'(c_nb - 1);
    localparam logic [c_rcw-1:0] c_last_rd   = c_rcw'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t           r_state_q, w_state_d;
    logic [c_bcw-1:0] r_beat_q,  w_beat_d;
    logic [c_rcw-1:0] r_rd_q,    w_rd_d;
    logic             r_dir_q,   w_dir_d;
    logic             r_err_q,   w_err_d;
    logic             r_ovr_q,   w_ovr_d;
    logic             r_done_q,  w_done_d;
    logic [W-1:0]     r_prev_q,  w_prev_d;
    logic [W-1:0]     r_buf_q [N];
    logic [W-1:0]     w_buf_d [N];
    logic [W-1:0]     w_lane  [P];
    logic             w_accept;
    logic             w_store;
    logic             w_dir_eff;
    logic             w_viol;

    // True when the pair (lo earlier, hi later) breaks the requested order.
    function automatic logic f_bad(input logic [W-1:0] lo, input logic [W-1:0] hi,
                                   input logic dir);
        return dir ? (lo < hi) : (lo > hi);
    endfunction

    for (genvar g = 0; g < P; g++) begin : g_lane
        assign w_lane[g] = DI[g*W +: W];
    end

    // Order check of the incoming beat. Beat 0 has no predecessor, so the
    // cross-beat compare against the previous beat's last lane is only done
    // while collecting. In IDLE the direction comes straight from INV since
    // the direction register is loaded on that same edge.
    always_comb begin
        w_accept  = Vin & ENin;
        w_dir_eff = (r_state_q == S_IDLE) ? INV : r_dir_q;
        w_viol    = (r_state_q == S_COLLECT) && f_bad(r_prev_q, w_lane[0], w_dir_eff);
        for (int i = 1; i < P; i++) begin
            if (f_bad(w_lane[i-1], w_lane[i], w_dir_eff)) begin
                w_viol = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_beat_d  = r_beat_q;
        w_rd_d    = r_rd_q;
        w_dir_d   = r_dir_q;
        w_err_d   = r_err_q;
        w_ovr_d   = r_ovr_q;
        w_done_d  = 1'b0;
        w_prev_d  = r_prev_q;
        w_store   = 1'b0;
        w_buf_d   = r_buf_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_store  = 1'b1;
                    w_dir_d  = INV;
                    w_err_d  = w_viol;
                    w_prev_d = w_lane[P-1];
                    if (c_nb == 1) begin
                        w_state_d = S_DRAIN;
                        w_beat_d  = '0;
                    end else begin
                        w_state_d = S_COLLECT;
                        w_beat_d  = c_bcw'(1);
                    end
                end
            end
            S_COLLECT: begin
                if (w_accept) begin
                    w_store  = 1'b1;
                    w_err_d  = r_err_q | w_viol;
                    w_prev_d = w_lane[P-1];
                    if (r_beat_q == c_last_beat) begin
                        w_state_d = S_DRAIN;
                        w_beat_d  = '0;
                    end else begin
                        w_beat_d = r_beat_q + c_bcw'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Beats offered while draining are dropped; only the flag records them.
                if (w_accept) begin
                    w_ovr_d = 1'b1;
                end
                if (RDY) begin
                    if (r_rd_q == c_last_rd) begin
                        w_rd_d    = '0;
                        w_done_d  = 1'b1;
                        w_state_d = S_IDLE;
                    end else begin
                        w_rd_d = r_rd_q + c_rcw'(1);
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // r_beat_q is 0 in IDLE, so the same slot select serves beat 0 and later beats.
        if (w_store) begin
            for (int j = 0; j < N; j++) begin
                if ((j / P) == int'(r_beat_q)) begin
                    w_buf_d[j] = w_lane[j % P];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= S_IDLE;
            r_beat_q  <= '0;
            r_rd_q    <= '0;
            r_dir_q   <= 1'b0;
            r_err_q   <= 1'b0;
            r_ovr_q   <= 1'b0;
            r_done_q  <= 1'b0;
            r_prev_q  <= '0;
            for (int k = 0; k < N; k++) begin
                r_buf_q[k] <= '0;
            end
        end else begin
            r_state_q <= w_state_d;
            r_beat_q  <= w_beat_d;
            r_rd_q    <= w_rd_d;
            r_dir_q   <= w_dir_d;
            r_err_q   <= w_err_d;
            r_ovr_q   <= w_ovr_d;
            r_done_q  <= w_done_d;
            r_prev_q  <= w_prev_d;
            r_buf_q   <= w_buf_d;
        end
    end

    // Outputs decode registered state only, so they hold steady under backpressure.
    assign Vo       = (r_state_q == S_DRAIN);
    assign DOut     = Vo ? r_buf_q[r_rd_q] : '0;
    assign Last     = Vo && (r_rd_q == c_last_rd);
    assign Done     = r_done_q;
    assign OrderErr = r_err_q;
    assign Overrun  = r_ovr_q;
    assign Busy     = (r_state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_oem_bisu_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_oem_bisu_result_drain
// Purpose  : Scoreboard bench for oem_bisu_result_drain. Frames are issued
//            with the expected element stream queued; a monitor pops and
//            compares each element as it is handed downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oem_bisu_result_drain;

    localparam int W  = 6;
    localparam int P  = 4;
    localparam int N  = 16;
    localparam int NB = N / P;

    logic           clk  = 1'b0;
    logic           rst  = 1'b0;
    logic           ENin = 1'b0;
    logic           Vin  = 1'b0;
    logic           INV  = 1'b0;
    logic           RDY  = 1'b0;
    logic [P*W-1:0] DI   = '0;
    logic [W-1:0]   DOut;
    logic           Vo, Last, Done, OrderErr, Overrun, Busy;

    oem_bisu_result_drain #(.W(W), .P(P), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .ENin     (ENin),
        .Vin      (Vin),
        .INV      (INV),
        .DI       (DI),
        .RDY      (RDY),
        .DOut     (DOut),
        .Vo       (Vo),
        .Last     (Last),
        .Done     (Done),
        .OrderErr (OrderErr),
        .Overrun  (Overrun),
        .Busy     (Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         last;
        logic         err;
    } exp_t;

    exp_t         sbq[$];
    int           total   = 0;
    int           bad     = 0;
    int           pop_idx = 0;
    bit           exp_done = 1'b0;
    bit           stall    = 1'b0;
    logic [W-1:0] held     = '0;
    int           rdy_mode = 0;
    int           rdy_pat  = 0;
    logic [W-1:0] frm [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready generator: 0 always, 1 random, 2 pattern 1,0,0,1, 3 held low.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       RDY = 1'b1;
                1:       RDY = 1'($urandom_range(0, 1));
                2: begin
                    RDY = ((rdy_pat % 4) == 0) || ((rdy_pat % 4) == 3);
                    rdy_pat++;
                end
                default: RDY = 1'b0;
            endcase
        end
    end

    // Monitor: checks every downstream handshake, output stability under
    // backpressure, and the Done pulse following the last element.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall    = 1'b0;
                exp_done = 1'b0;
            end else begin
                chk("done_pulse", Done, exp_done);
                exp_done = 1'b0;
                if (stall) begin
                    chk("hold_vo", Vo, 1);
                    chk("hold_dout", DOut, held);
                end
                if (Vo && RDY) begin
                    stall = 1'b0;
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_elem: got %0d want none at %0t", DOut, $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("dout", DOut, e.d);
                        chk("last", Last, e.last);
                        chk("order_err", OrderErr, e.err);
                        pop_idx++;
                        if (e.last) begin
                            exp_done = 1'b1;
                            pop_idx  = 0;
                        end
                    end
                end else if (Vo) begin
                    stall = 1'b1;
                    held  = DOut;
                end else begin
                    stall = 1'b0;
                end
            end
        end
    end

    // Issue the first nbeats beats of frm. Full frames queue their expected
    // stream; the order flag is derived from the whole frame as one sequence.
    task automatic send_frame(input bit inv, input int nbeats, input int gap_b,
                              input int gap_n, input bit rnd_gap);
        bit err;
        int g;
        int sel;
        err = 1'b0;
        if (nbeats == NB) begin
            for (int i = 1; i < N; i++) begin
                if (inv ? (frm[i-1] < frm[i]) : (frm[i-1] > frm[i])) err = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                sbq.push_back('{d: frm[i], last: (i == N-1), err: err});
            end
        end
        for (int b = 0; b < nbeats; b++) begin
            g = rnd_gap ? int'($urandom_range(0, 2)) : ((b == gap_b) ? gap_n : 0);
            repeat (g) begin
                sel  = int'($urandom_range(0, 2));
                Vin  = (sel == 1);
                ENin = (sel == 2);
                DI   = P*W'($urandom);
                @(posedge clk);
                #2;
            end
            Vin  = 1'b1;
            ENin = 1'b1;
            INV  = (b == 0) ? inv : 1'($urandom_range(0, 1));
            for (int l = 0; l < P; l++) DI[l*W +: W] = frm[b*P + l];
            if (b == NB-1) begin
                @(negedge clk);
                chk("vo_before_last_beat", Vo, 0);
            end
            @(posedge clk);
            #2;
            Vin  = 1'b0;
            ENin = 1'b0;
            if (b == 0) chk("busy_after_beat0", Busy, 1);
        end
        if (nbeats == NB) chk("vo_latency", Vo, 1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (Done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got none want Done at %0t", $time);
        end else begin
            chk("busy_after_done", Busy, 0);
            chk("queue_empty", sbq.size(), 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_vo", Vo, 0);
        chk("rst_dout", DOut, 0);
        chk("rst_last", Last, 0);
        chk("rst_done", Done, 0);
        chk("rst_ordererr", OrderErr, 0);
        chk("rst_overrun", Overrun, 0);
        chk("rst_busy", Busy, 0);
        sbq.delete();
        pop_idx = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic load_asc();
        logic [W-1:0] a [N];
        a = '{7, 10, 12, 13, 19, 22, 25, 29, 33, 38, 40, 45, 50, 52, 55, 59};
        frm = a;
    endtask

    task automatic load_desc();
        load_asc();
        for (int i = 0; i < N/2; i++) begin
            logic [W-1:0] t;
            t = frm[i];
            frm[i] = frm[N-1-i];
            frm[N-1-i] = t;
        end
    endtask

    initial begin
        logic [W-1:0] q[$];
        bit           inv;
        bit           seen;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        do_reset();

        // Ascending frame, ready always high
        rdy_mode = 0;
        load_asc();
        send_frame(1'b0, NB, -1, 0, 1'b0);
        wait_done();

        // Backpressure 1,0,0,1 and a two-cycle gap before beat 2
        rdy_pat  = 0;
        rdy_mode = 2;
        send_frame(1'b0, NB, 2, 2, 1'b0);
        wait_done();
        rdy_mode = 0;

        // Order violation inside beat 2, then an all-equal frame
        load_asc();
        frm[9]  = 6'd40;
        frm[10] = 6'd38;
        send_frame(1'b0, NB, -1, 0, 1'b0);
        wait_done();
        for (int i = 0; i < N; i++) frm[i] = 6'd63;
        send_frame(1'b0, NB, -1, 0, 1'b0);
        wait_done();

        // Descending frame under both directions
        load_desc();
        send_frame(1'b1, NB, -1, 0, 1'b0);
        wait_done();
        send_frame(1'b0, NB, -1, 0, 1'b0);
        wait_done();
        chk("overrun_still_clear", Overrun, 0);

        // Random frames, random gaps and random ready
        rdy_mode = 1;
        for (int f = 0; f < 20; f++) begin
            q.delete();
            for (int i = 0; i < N; i++) q.push_back(W'($urandom));
            inv = 1'($urandom_range(0, 1));
            if (inv) q.rsort(); else q.sort();
            for (int i = 0; i < N; i++) frm[i] = q[i];
            if ($urandom_range(0, 3) == 0) begin
                int k;
                logic [W-1:0] t;
                k = int'($urandom_range(0, N-2));
                t = frm[k];
                frm[k] = frm[k+1];
                frm[k+1] = t;
            end
            send_frame(inv, NB, -1, 0, 1'b1);
            wait_done();
        end

        // Overrun: zero beat offered during drain with ready held low
        rdy_mode = 3;
        load_asc();
        send_frame(1'b0, NB, -1, 0, 1'b0);
        Vin  = 1'b1;
        ENin = 1'b1;
        DI   = '0;
        @(posedge clk);
        #2;
        Vin  = 1'b0;
        ENin = 1'b0;
        chk("overrun_set", Overrun, 1);
        repeat (3) @(posedge clk);
        rdy_mode = 0;
        wait_done();
        chk("overrun_sticky", Overrun, 1);

        // Reset after beat 2 of a frame
        @(posedge clk);
        #2;
        send_frame(1'b0, 3, -1, 0, 1'b0);
        #1;
        do_reset();

        // Full frame after reset, then reset at rd=5 mid-drain
        load_asc();
        send_frame(1'b0, NB, -1, 0, 1'b0);
        wait_done();
        send_frame(1'b0, NB, -1, 0, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (pop_idx >= 5) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL rd5_timeout: got %0d want 5 at %0t", pop_idx, $time);
        end
        do_reset();

        // Recovery frame
        load_desc();
        send_frame(1'b1, NB, -1, 0, 1'b0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
